// File: rtl/debug_link_pkg.sv
// Shared definitions for the 40-bit debug serial link: word width, receiver
// state encoding and error counter width. Used by transmitter and receiver.
package debug_link_pkg;

    localparam int DEBUG_WORD_W = 40;
    localparam int ERR_CNT_W    = 8;

    typedef enum logic [1:0] {
        RX_HOLD  = 2'd0,
        RX_IDLE  = 2'd1,
        RX_SHIFT = 2'd2
    } rx_state_e;

endpackage

// File: rtl/debug_data_receiver_if.sv
// Bundle of the serial-line inputs and the parallel word/status outputs of
// the debug receiver. The master modport is the receiver; the slave modport
// is the line driver and word consumer.
interface debug_data_receiver_if
    import debug_link_pkg::*;
#(
    parameter int WIDTH = DEBUG_WORD_W
);
    logic                 frame_in;
    logic                 sin;
    logic                 data_ready;
    logic [WIDTH-1:0]     data;
    logic                 data_valid;
    logic                 busy;
    logic                 err_short;
    logic                 err_long;
    logic                 overrun;
    logic [ERR_CNT_W-1:0] err_count;

    modport master (
        input  frame_in, sin, data_ready,
        output data, data_valid, busy, err_short, err_long, overrun, err_count
    );

    modport slave (
        output frame_in, sin, data_ready,
        input  data, data_valid, busy, err_short, err_long, overrun, err_count
    );

endinterface

// File: rtl/debug_rx_out_reg.sv
// Output holding register of the debug receiver. Owns the valid/ready
// handshake: a publish strobe loads a new word when the slot is free or is
// being emptied this cycle; otherwise the new word is dropped and overrun
// pulses for one cycle.
module debug_rx_out_reg #(
    parameter int WIDTH = 40
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             publish,
    input  logic [WIDTH-1:0] word,
    input  logic             data_ready,
    output logic [WIDTH-1:0] data,
    output logic             data_valid,
    output logic             overrun
);

    logic [WIDTH-1:0] data_r;
    logic [WIDTH-1:0] data_nxt_s;
    logic             valid_r;
    logic             valid_nxt_s;
    logic             overrun_r;
    logic             overrun_nxt_s;
    logic             handshake_s;

    assign handshake_s = valid_r & data_ready;

    // Decide next holding-register contents from publish and handshake.
    always_comb begin
        data_nxt_s    = data_r;
        valid_nxt_s   = valid_r;
        overrun_nxt_s = 1'b0;
        if (publish) begin
            if (!valid_r || handshake_s) begin
                data_nxt_s  = word;
                valid_nxt_s = 1'b1;
            end else begin
                overrun_nxt_s = 1'b1;
            end
        end else if (handshake_s) begin
            valid_nxt_s = 1'b0;
        end else begin
            valid_nxt_s = valid_r;
        end
    end

    // Holding register, valid flag and overrun pulse.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_r    <= {WIDTH{1'b0}};
            valid_r   <= 1'b0;
            overrun_r <= 1'b0;
        end else begin
            data_r    <= data_nxt_s;
            valid_r   <= valid_nxt_s;
            overrun_r <= overrun_nxt_s;
        end
    end

    assign data       = data_r;
    assign data_valid = valid_r;
    assign overrun    = overrun_r;

endmodule

// File: rtl/debug_data_receiver.sv
// Receiving end of the debug serial link. Reassembles LSB-first frames
// qualified by frame_in into parallel words, flags short/long frames and
// output overruns. Optional feature macro: DEBUG_RX_ERRCNT_EN enables the
// saturating err_count; without it err_count is tied to zero.
module debug_data_receiver
    import debug_link_pkg::*;
#(
    parameter int WIDTH = DEBUG_WORD_W,
    parameter int CNT_W = 6
) (
    input  logic                  clk,
    input  logic                  reset,
    debug_data_receiver_if.master bus
);

    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(WIDTH);
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

    rx_state_e        state_r;
    rx_state_e        state_nxt_s;
    logic [WIDTH-1:0] shift_r;
    logic [WIDTH-1:0] shift_nxt_s;
    logic [CNT_W-1:0] count_r;
    logic [CNT_W-1:0] count_nxt_s;
    logic             busy_r;
    logic             busy_nxt_s;
    logic             err_short_r;
    logic             err_short_nxt_s;
    logic             err_long_r;
    logic             err_long_nxt_s;
    logic             publish_s;
    logic [WIDTH-1:0] data_s;
    logic             data_valid_s;
    logic             overrun_s;

    // Next-state, shift-register and error-pulse decisions.
    always_comb begin
        state_nxt_s     = state_r;
        shift_nxt_s     = shift_r;
        count_nxt_s     = count_r;
        err_short_nxt_s = 1'b0;
        err_long_nxt_s  = 1'b0;
        publish_s       = 1'b0;
        case (state_r)
            RX_HOLD: begin
                // A frame in flight at entry is ignored until it ends.
                if (!bus.frame_in) begin
                    state_nxt_s = RX_IDLE;
                end else begin
                    state_nxt_s = RX_HOLD;
                end
            end
            RX_IDLE: begin
                if (bus.frame_in) begin
                    shift_nxt_s = {bus.sin, shift_r[WIDTH-1:1]};
                    count_nxt_s = CNT_ONE;
                    state_nxt_s = RX_SHIFT;
                end else begin
                    state_nxt_s = RX_IDLE;
                end
            end
            RX_SHIFT: begin
                if (bus.frame_in) begin
                    if (count_r == CNT_FULL) begin
                        err_long_nxt_s = 1'b1;
                        count_nxt_s    = CNT_ZERO;
                        state_nxt_s    = RX_HOLD;
                    end else begin
                        shift_nxt_s = {bus.sin, shift_r[WIDTH-1:1]};
                        count_nxt_s = count_r + CNT_ONE;
                    end
                end else begin
                    count_nxt_s = CNT_ZERO;
                    state_nxt_s = RX_IDLE;
                    if (count_r == CNT_FULL) begin
                        publish_s = 1'b1;
                    end else begin
                        err_short_nxt_s = 1'b1;
                    end
                end
            end
            default: begin
                count_nxt_s = CNT_ZERO;
                state_nxt_s = RX_HOLD;
            end
        endcase
        busy_nxt_s = (state_nxt_s == RX_SHIFT);
    end

    // State, shift register, bit counter and registered status outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r     <= RX_HOLD;
            shift_r     <= {WIDTH{1'b0}};
            count_r     <= CNT_ZERO;
            busy_r      <= 1'b0;
            err_short_r <= 1'b0;
            err_long_r  <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            shift_r     <= shift_nxt_s;
            count_r     <= count_nxt_s;
            busy_r      <= busy_nxt_s;
            err_short_r <= err_short_nxt_s;
            err_long_r  <= err_long_nxt_s;
        end
    end

    debug_rx_out_reg #(
        .WIDTH (WIDTH)
    ) u_out_reg (
        .clk        (clk),
        .reset      (reset),
        .publish    (publish_s),
        .word       (shift_r),
        .data_ready (bus.data_ready),
        .data       (data_s),
        .data_valid (data_valid_s),
        .overrun    (overrun_s)
    );

`ifdef DEBUG_RX_ERRCNT_EN
    localparam logic [ERR_CNT_W-1:0] ERR_MAX = {ERR_CNT_W{1'b1}};
    localparam logic [ERR_CNT_W-1:0] ERR_ONE = {{(ERR_CNT_W-1){1'b0}}, 1'b1};

    logic [ERR_CNT_W-1:0] err_count_r;
    logic                 err_any_s;

    assign err_any_s = err_short_r | err_long_r | overrun_s;

    // Saturating count of cycles on which any error pulse is visible.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_count_r <= {ERR_CNT_W{1'b0}};
        end else if (err_any_s && (err_count_r != ERR_MAX)) begin
            err_count_r <= err_count_r + ERR_ONE;
        end else begin
            err_count_r <= err_count_r;
        end
    end

    assign bus.err_count = err_count_r;
`else
    assign bus.err_count = {ERR_CNT_W{1'b0}};
`endif

    assign bus.data       = data_s;
    assign bus.data_valid = data_valid_s;
    assign bus.busy       = busy_r;
    assign bus.err_short  = err_short_r;
    assign bus.err_long   = err_long_r;
    assign bus.overrun    = overrun_s;

endmodule

// File: tb/tb_debug_data_receiver.sv
// Directed bench for debug_data_receiver: a table of frames with expected
// word/status results, plus hand-written reset-mid-frame and error-counter
// saturation sequences.
module tb_debug_data_receiver;

    logic clk;
    logic reset;

    debug_data_receiver_if #(.WIDTH(40)) bus ();

    debug_data_receiver #(.WIDTH(40), .CNT_W(6)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [39:0] word;
        int          len;
        logic        ready;
        logic        exp_dv;
        logic [39:0] exp_data;
        int          exp_short;
        int          exp_long;
        int          exp_ovr;
        int          exp_busy;
    } vec_t;

    vec_t vecs [10];

    int checks   = 0;
    int failures = 0;

    int          n_short, n_long, n_ovr, n_busy, n_dv;
    logic        dv_end;
    logic [39:0] data_end;

`ifdef DEBUG_RX_ERRCNT_EN
    localparam int ERRCNT_ON = 1;
`else
    localparam int ERRCNT_ON = 0;
`endif

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Advance to just after the next rising edge and tally visible pulses.
    task automatic tick();
        @(posedge clk);
        #1;
        if (bus.err_short)  n_short++;
        if (bus.err_long)   n_long++;
        if (bus.overrun)    n_ovr++;
        if (bus.busy)       n_busy++;
        if (bus.data_valid) n_dv++;
    endtask

    task automatic clear_tally();
        n_short = 0; n_long = 0; n_ovr = 0; n_busy = 0; n_dv = 0;
    endtask

    // Drive frame_in high for len cycles (LSB first), then one low cycle.
    task automatic send_frame(input logic [39:0] word, input int len, input logic ready);
        bus.data_ready = ready;
        clear_tally();
        for (int i = 0; i < len; i++) begin
            bus.frame_in = 1'b1;
            bus.sin      = (i < 40) ? word[i] : 1'b0;
            tick();
        end
        bus.frame_in = 1'b0;
        bus.sin      = 1'b0;
        tick();
        dv_end   = bus.data_valid;
        data_end = bus.data;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_data"},      {24'd0, bus.data},  64'd0);
        check({tag, "_valid"},     {63'd0, bus.data_valid}, 64'd0);
        check({tag, "_busy"},      {63'd0, bus.busy},       64'd0);
        check({tag, "_err_short"}, {63'd0, bus.err_short},  64'd0);
        check({tag, "_err_long"},  {63'd0, bus.err_long},   64'd0);
        check({tag, "_overrun"},   {63'd0, bus.overrun},    64'd0);
        check({tag, "_err_count"}, {56'd0, bus.err_count},  64'd0);
    endtask

    initial begin
        vecs[0] = '{"full_a99",   40'hA999999991, 40, 1'b0, 1'b1, 40'hA999999991, 0, 0, 0, 40};
        vecs[1] = '{"b2b_first",  40'h123456789A, 40, 1'b1, 1'b1, 40'h123456789A, 0, 0, 0, 40};
        vecs[2] = '{"b2b_second", 40'h0F0F0F0F0F, 40, 1'b1, 1'b1, 40'h0F0F0F0F0F, 0, 0, 0, 40};
        vecs[3] = '{"short25",    40'hFFFFFFFFFF, 25, 1'b1, 1'b0, 40'h0F0F0F0F0F, 1, 0, 0, 25};
        vecs[4] = '{"after_short",40'h5555555555, 40, 1'b0, 1'b1, 40'h5555555555, 0, 0, 0, 40};
        vecs[5] = '{"overrun",    40'h3C3C3C3C3C, 40, 1'b0, 1'b1, 40'h5555555555, 0, 0, 1, 40};
        vecs[6] = '{"long43",     40'hAAAAAAAAAA, 43, 1'b1, 1'b0, 40'h5555555555, 0, 1, 0, 40};
        vecs[7] = '{"one_cycle",  40'hFFFFFFFFFF,  1, 1'b1, 1'b0, 40'h5555555555, 1, 0, 0,  1};
        vecs[8] = '{"lsb_only",   40'h0000000001, 40, 1'b1, 1'b1, 40'h0000000001, 0, 0, 0, 40};
        vecs[9] = '{"msb_only",   40'h8000000000, 40, 1'b1, 1'b1, 40'h8000000000, 0, 0, 0, 40};

        reset          = 1'b1;
        bus.frame_in   = 1'b0;
        bus.sin        = 1'b0;
        bus.data_ready = 1'b0;
        clear_tally();
        tick();
        tick();
        check_all_zero("reset");
        reset = 1'b0;
        tick();
        tick();

        // Table-driven frames.
        for (int v = 0; v < 10; v++) begin
            send_frame(vecs[v].word, vecs[v].len, vecs[v].ready);
            check({vecs[v].name, "_valid"}, {63'd0, dv_end}, {63'd0, vecs[v].exp_dv});
            check({vecs[v].name, "_data"},  {24'd0, data_end}, {24'd0, vecs[v].exp_data});
            check({vecs[v].name, "_short"}, 64'(n_short), 64'(vecs[v].exp_short));
            check({vecs[v].name, "_long"},  64'(n_long),  64'(vecs[v].exp_long));
            check({vecs[v].name, "_ovr"},   64'(n_ovr),   64'(vecs[v].exp_ovr));
            check({vecs[v].name, "_busy"},  64'(n_busy),  64'(vecs[v].exp_busy));
            check({vecs[v].name, "_idle"},  {63'd0, bus.busy}, 64'd0);
        end
        check("errcnt_after_table", {56'd0, bus.err_count}, (ERRCNT_ON != 0) ? 64'd4 : 64'd0);

        // Reset asserted at bit 17 and released while frame_in is still high.
        bus.data_ready = 1'b1;
        clear_tally();
        for (int i = 0; i < 17; i++) begin
            bus.frame_in = 1'b1;
            bus.sin      = i[0];
            tick();
        end
        reset = 1'b1;
        #1;
        check_all_zero("midreset");
        for (int i = 17; i < 20; i++) begin
            bus.sin = i[0];
            tick();
        end
        reset = 1'b0;
        clear_tally();
        for (int i = 20; i < 40; i++) begin
            bus.sin = i[0];
            tick();
        end
        bus.frame_in = 1'b0;
        bus.sin      = 1'b0;
        tick();
        check("midreset_no_valid", 64'(n_dv),    64'd0);
        check("midreset_no_busy",  64'(n_busy),  64'd0);
        check("midreset_no_short", 64'(n_short), 64'd0);
        check("midreset_no_long",  64'(n_long),  64'd0);

        send_frame(40'hDEADBEEF01, 40, 1'b0);
        check("post_reset_valid", {63'd0, dv_end}, 64'd1);
        check("post_reset_data",  {24'd0, data_end}, {24'd0, 40'hDEADBEEF01});
        check("post_reset_short", 64'(n_short), 64'd0);

        // Inject short frames to drive the error counter into saturation.
        for (int k = 0; k < 100; k++) begin
            send_frame(40'h0, 1, 1'b0);
        end
        tick();
        check("errcnt_100", {56'd0, bus.err_count}, (ERRCNT_ON != 0) ? 64'd100 : 64'd0);
        for (int k = 0; k < 200; k++) begin
            send_frame(40'h0, 1, 1'b0);
        end
        tick();
        tick();
        check("errcnt_sat", {56'd0, bus.err_count}, (ERRCNT_ON != 0) ? 64'd255 : 64'd0);
        check("held_word_kept", {24'd0, bus.data}, {24'd0, 40'hDEADBEEF01});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
